// File: rtl/buffer_fill_unit_pkg.sv
// rtl/buffer_fill_unit_pkg.sv - shared sizes, FSM encodings and count saturation for the operand buffers
package buffer_pkg;

  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int MEM_AW = 10;
  localparam int DW     = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Requests larger than the buffer are clipped to a full-buffer fill.
  function automatic logic [AW:0] sat_count(input logic [AW:0] count);
    if (count > (AW+1)'(DEPTH)) begin
      return (AW+1)'(DEPTH);
    end
    return count;
  endfunction

endpackage

// File: rtl/buffer_fill_unit_if.sv
// rtl/buffer_fill_unit_if.sv - fill request, memory port B and buffer read-port bundle
interface buffer_fill_if;
  import buffer_pkg::*;

  logic              Start;
  logic              BufSel;
  logic [MEM_AW-1:0] BaseAddr;
  logic [AW:0]       Count;
  logic [MEM_AW-1:0] MEM_Address_2;
  logic [DW-1:0]     MEM_ReadData_B;
  logic              Busy;
  logic              Done;
  logic              buf_a_valid;
  logic              buf_b_valid;
  logic [AW-1:0]     buf_val_1_addr;
  logic [DW-1:0]     buf_val_1_select;
  logic [AW-1:0]     buf_val_2_addr;
  logic [DW-1:0]     buf_val_2_select;

  modport slave (
    input  Start, BufSel, BaseAddr, Count, MEM_ReadData_B, buf_val_1_addr, buf_val_2_addr,
    output MEM_Address_2, Busy, Done, buf_a_valid, buf_b_valid, buf_val_1_select, buf_val_2_select
  );

  modport master (
    output Start, BufSel, BaseAddr, Count, MEM_ReadData_B, buf_val_1_addr, buf_val_2_addr,
    input  MEM_Address_2, Busy, Done, buf_a_valid, buf_b_valid, buf_val_1_select, buf_val_2_select
  );

endinterface

// File: rtl/buffer_fill_unit_bank.sv
// rtl/buffer_fill_unit_bank.sv - DEPTH x DW register file, one sync write, one async read, async clear
module buffer_bank
  import buffer_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Entry storage: cleared on reset, one word written per enabled edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reading the register array directly means a same-edge write is not yet visible.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/buffer_fill_unit.sv
// rtl/buffer_fill_unit.sv - fills operand buffer A or B from data-memory port B and exposes both read ports
module buffer_fill_unit
  import buffer_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  buffer_fill_if.slave bus
);

  logic [1:0]        r_state;
  logic              r_sel;
  logic [MEM_AW-1:0] r_addr;
  logic [AW:0]       r_n;
  logic [AW-1:0]     r_k;
  logic              r_wr_valid;
  logic [AW-1:0]     r_wr_idx;
  logic              r_a_valid;
  logic              r_b_valid;

  logic [AW:0]       w_count_sat;
  logic [AW:0]       w_n_m1;
  logic              w_last;
  logic              w_we_a;
  logic              w_we_b;

  assign w_count_sat = sat_count(bus.Count);
  assign w_n_m1      = r_n - (AW+1)'(1);
  assign w_last      = ({1'b0, r_k} == w_n_m1);

  // Fill sequencer: one address per ISSUE cycle, the delay register follows it by one cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_sel      <= 1'b0;
      r_addr     <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_wr_valid <= 1'b0;
      r_wr_idx   <= '0;
      r_a_valid  <= 1'b0;
      r_b_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wr_valid <= 1'b0;
          if (bus.Start) begin
            r_sel <= bus.BufSel;
            r_n   <= w_count_sat;
            r_k   <= '0;
            if (bus.BufSel) begin
              r_b_valid <= 1'b0;
            end else begin
              r_a_valid <= 1'b0;
            end
            if (w_count_sat == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_addr  <= bus.BaseAddr;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_wr_valid <= 1'b1;
          r_wr_idx   <= r_k;
          if (w_last) begin
            r_state <= ST_DRAIN;
          end else begin
            r_k    <= r_k + AW'(1);
            r_addr <= r_addr + MEM_AW'(1);
          end
        end
        ST_DRAIN: begin
          r_wr_valid <= 1'b0;
          r_state    <= ST_DONE;
        end
        default: begin
          if (r_sel) begin
            r_b_valid <= 1'b1;
          end else begin
            r_a_valid <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_we_a = r_wr_valid & ~r_sel;
  assign w_we_b = r_wr_valid & r_sel;

  buffer_bank u_bank_a (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_we    (w_we_a),
    .i_waddr (r_wr_idx),
    .i_wdata (bus.MEM_ReadData_B),
    .i_raddr (bus.buf_val_1_addr),
    .o_rdata (bus.buf_val_1_select)
  );

  buffer_bank u_bank_b (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_we    (w_we_b),
    .i_waddr (r_wr_idx),
    .i_wdata (bus.MEM_ReadData_B),
    .i_raddr (bus.buf_val_2_addr),
    .o_rdata (bus.buf_val_2_select)
  );

  assign bus.MEM_Address_2 = r_addr;
  assign bus.Busy          = (r_state != ST_IDLE);
  assign bus.Done          = (r_state == ST_DONE);
  assign bus.buf_a_valid   = r_a_valid;
  assign bus.buf_b_valid   = r_b_valid;

endmodule

// File: tb/tb_buffer_fill_unit.sv
// tb/tb_buffer_fill_unit.sv - randomized self-checking bench for buffer_fill_unit
module tb_buffer_fill_unit;

  logic clk;
  logic rst;
  buffer_fill_if bus ();

  buffer_fill_unit dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [1024];
  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  logic        m_va;
  logic        m_vb;
  logic [9:0]  m_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: address seen in one cycle, data presented through the next.
  initial begin
    logic [9:0] a;
    bus.MEM_ReadData_B = '0;
    forever begin
      @(negedge clk);
      a = bus.MEM_Address_2;
      @(posedge clk);
      #1;
      bus.MEM_ReadData_B = mem[a];
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    m_va = 1'b0;
    m_vb = 1'b0;
    m_addr = '0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.buf_val_1_addr = 5'(i);
      bus.buf_val_2_addr = 5'(i);
      #1;
      n_checks++;
      if (bus.buf_val_1_select !== m_a[i]) begin
        n_fail++;
        $display("FAIL %s A[%0d]: got %h expected %h", tag, i, bus.buf_val_1_select, m_a[i]);
      end
      n_checks++;
      if (bus.buf_val_2_select !== m_b[i]) begin
        n_fail++;
        $display("FAIL %s B[%0d]: got %h expected %h", tag, i, bus.buf_val_2_select, m_b[i]);
      end
    end
    n_checks++;
    if (bus.buf_a_valid !== m_va || bus.buf_b_valid !== m_vb) begin
      n_fail++;
      $display("FAIL %s valid: got a=%b b=%b expected a=%b b=%b", tag,
               bus.buf_a_valid, bus.buf_b_valid, m_va, m_vb);
    end
  endtask

  task automatic run_fill(input logic sel, input logic [9:0] base, input logic [5:0] cnt,
                          input int hold1, input bit restart, input string tag);
    int n, done_cyc, i1, i2, dones;
    logic [31:0] nw [32];
    logic [31:0] e1, e2;
    logic [9:0]  ea;
    logic        eva, evb;
    n = (cnt > 6'd32) ? 32 : int'(cnt);
    done_cyc = (n == 0) ? 0 : n + 1;
    for (int k = 0; k < 32; k++) nw[k] = '0;
    for (int k = 0; k < n; k++) nw[k] = mem[base + 10'(k)];
    i1 = (hold1 >= 0) ? hold1 : int'($urandom_range(0, 31));
    i2 = int'($urandom_range(0, 31));
    dones = 0;
    @(negedge clk);
    bus.buf_val_1_addr = 5'(i1);
    bus.buf_val_2_addr = 5'(i2);
    bus.Start = 1'b1;
    bus.BufSel = sel;
    bus.BaseAddr = base;
    bus.Count = cnt;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.BufSel = 1'($urandom);
    bus.BaseAddr = 10'($urandom);
    bus.Count = 6'($urandom);
    for (int cyc = 0; cyc <= n + 3; cyc++) begin
      @(negedge clk);
      ea = (n == 0) ? m_addr : ((cyc < n) ? base + 10'(cyc) : base + 10'(n - 1));
      n_checks++;
      if (bus.MEM_Address_2 !== ea) begin
        n_fail++;
        $display("FAIL %s addr cyc%0d: got %h expected %h", tag, cyc, bus.MEM_Address_2, ea);
      end
      n_checks++;
      if (bus.Busy !== (cyc <= done_cyc) || bus.Done !== (cyc == done_cyc)) begin
        n_fail++;
        $display("FAIL %s busy/done cyc%0d: got %b/%b expected %b/%b", tag, cyc,
                 bus.Busy, bus.Done, (cyc <= done_cyc), (cyc == done_cyc));
      end
      if (bus.Done === 1'b1) dones++;
      e1 = (sel == 1'b0 && i1 < n && cyc >= i1 + 2) ? nw[i1] : m_a[i1];
      e2 = (sel == 1'b1 && i2 < n && cyc >= i2 + 2) ? nw[i2] : m_b[i2];
      n_checks++;
      if (bus.buf_val_1_select !== e1 || bus.buf_val_2_select !== e2) begin
        n_fail++;
        $display("FAIL %s read cyc%0d: got A[%0d]=%h B[%0d]=%h expected %h %h", tag, cyc,
                 i1, bus.buf_val_1_select, i2, bus.buf_val_2_select, e1, e2);
      end
      if (cyc != done_cyc) begin
        eva = (sel == 1'b0) ? 1'(cyc > done_cyc) : m_va;
        evb = (sel == 1'b1) ? 1'(cyc > done_cyc) : m_vb;
        n_checks++;
        if (bus.buf_a_valid !== eva || bus.buf_b_valid !== evb) begin
          n_fail++;
          $display("FAIL %s valid cyc%0d: got a=%b b=%b expected a=%b b=%b", tag, cyc,
                   bus.buf_a_valid, bus.buf_b_valid, eva, evb);
        end
      end
      if (restart && cyc == 1) begin
        bus.Start = 1'b1;
        bus.BufSel = ~sel;
        bus.BaseAddr = base + 10'h155;
        bus.Count = 6'd3;
      end
      if (restart && cyc == 2) bus.Start = 1'b0;
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL %s done pulses: got %0d expected 1", tag, dones);
    end
    for (int k = 0; k < n; k++) begin
      if (sel) m_b[k] = nw[k];
      else     m_a[k] = nw[k];
    end
    if (sel) m_vb = 1'b1;
    else     m_va = 1'b1;
    if (n > 0) m_addr = base + 10'(n - 1);
    check_all(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.MEM_Address_2 !== 10'h000) begin
      n_fail++;
      $display("FAIL reset outputs: got busy=%b done=%b addr=%h expected 0 0 000",
               bus.Busy, bus.Done, bus.MEM_Address_2);
    end
    rst = 1'b0;
    model_clear();
    check_all("reset");
  endtask

  task automatic test_basic_fill();
    run_fill(1'b0, 10'h010, 6'd4, -1, 1'b0, "basic");
    for (int i = 0; i < 4; i++) begin
      bus.buf_val_1_addr = 5'(i);
      #1;
      n_checks++;
      if (bus.buf_val_1_select !== 32'h1010 + 32'(i)) begin
        n_fail++;
        $display("FAIL basic A[%0d]: got %h expected %h", i, bus.buf_val_1_select, 32'h1010 + 32'(i));
      end
    end
    n_checks++;
    if (bus.buf_a_valid !== 1'b1 || bus.buf_b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic valid: got a=%b b=%b expected 1 0", bus.buf_a_valid, bus.buf_b_valid);
    end
  endtask

  task automatic test_wrap_full();
    run_fill(1'b1, 10'h3F0, 6'd32, -1, 1'b0, "wrap");
    bus.buf_val_2_addr = 5'd31;
    #1;
    n_checks++;
    if (bus.buf_val_2_select !== 32'h0000100F) begin
      n_fail++;
      $display("FAIL wrap B[31]: got %h expected 0000100f", bus.buf_val_2_select);
    end
  endtask

  task automatic test_zero_and_saturate();
    run_fill(1'b0, 10'($urandom), 6'd0, -1, 1'b0, "zero_a");
    run_fill(1'b1, 10'($urandom), 6'd0, -1, 1'b0, "zero_b");
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    run_fill(1'b0, 10'($urandom), 6'd45, -1, 1'b0, "saturate");
  endtask

  task automatic test_back_to_back();
    run_fill(1'b0, 10'h100, 6'd8, -1, 1'b1, "restart");
    run_fill(1'b1, 10'h3FC, 6'd8, -1, 1'b1, "restart_b");
  endtask

  task automatic test_reset_midfill();
    @(negedge clk);
    bus.Start = 1'b1;
    bus.BufSel = 1'($urandom);
    bus.BaseAddr = 10'($urandom);
    bus.Count = 6'd8;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.buf_a_valid !== 1'b0 ||
        bus.buf_b_valid !== 1'b0 || bus.MEM_Address_2 !== 10'h000) begin
      n_fail++;
      $display("FAIL midreset outputs: got busy=%b done=%b va=%b vb=%b addr=%h expected 0 0 0 0 000",
               bus.Busy, bus.Done, bus.buf_a_valid, bus.buf_b_valid, bus.MEM_Address_2);
    end
    model_clear();
    check_all("midreset_held");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset after cyc%0d: got busy=%b done=%b expected 0 0", c, bus.Busy, bus.Done);
      end
    end
    check_all("midreset");
  endtask

  task automatic test_read_during_fill();
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    run_fill(1'b0, 10'h200, 6'd32, -1, 1'b0, "prefill");
    run_fill(1'b0, 10'h080, 6'd8, 3, 1'b0, "hold3");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      run_fill(1'($urandom), 10'($urandom), 6'($urandom_range(0, 40)), -1, 1'($urandom), "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.BufSel = 1'b0;
    bus.BaseAddr = '0;
    bus.Count = '0;
    bus.buf_val_1_addr = '0;
    bus.buf_val_2_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i);
    test_reset();
    test_basic_fill();
    test_wrap_full();
    test_zero_and_saturate();
    test_back_to_back();
    test_reset_midfill();
    test_read_during_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
